register_file_mp: RTL and testbench

REGISTER_FILE_MP -- requirements
Module: register_file_mp

---
 rtl/register_file_mp_pkg.sv | 15 +
 rtl/register_file_mp_if.sv | 50 +++++
 rtl/rf_src_lookup.sv | 58 +++++
 rtl/register_file_mp.sv | 135 +++++++++++++
 tb/tb_register_file_mp.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_mp_pkg.sv
// Shared CPU constants and types for the rename register file.
package register_file_mp_pkg;

  localparam int REG_WIDTH    = 5;
  localparam int RoB_WIDTH    = 4;
  localparam int DP_N         = 2;
  localparam int CM_N         = 2;
  localparam int EX_REG_WIDTH = REG_WIDTH + 1;
  localparam int NON_REG      = 1 << REG_WIDTH;
  localparam int EX_RoB_WIDTH = RoB_WIDTH + 1;
  localparam int NON_DEP      = 1 << RoB_WIDTH;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/register_file_mp_if.sv
// Dispatch, commit, flush and debug bundle of the rename register file.
interface register_file_mp_if #(
    parameter int REG_WIDTH = register_file_mp_pkg::REG_WIDTH,
    parameter int RoB_WIDTH = register_file_mp_pkg::RoB_WIDTH,
    parameter int DP_N      = register_file_mp_pkg::DP_N,
    parameter int CM_N      = register_file_mp_pkg::CM_N
);
    import register_file_mp_pkg::word_t;

    logic Sys_rdy;

    logic [DP_N-1:0]                DPRF_en;
    logic [DP_N-1:0][REG_WIDTH:0]   DPRF_rd;
    logic [DP_N-1:0][REG_WIDTH:0]   DPRF_rs1;
    logic [DP_N-1:0][REG_WIDTH:0]   DPRF_rs2;
    logic [DP_N-1:0][RoB_WIDTH-1:0] DPRF_RoB_index;

    logic [DP_N-1:0][RoB_WIDTH:0]   RFDP_Qj;
    logic [DP_N-1:0][RoB_WIDTH:0]   RFDP_Qk;
    word_t [DP_N-1:0]               RFDP_Vj;
    word_t [DP_N-1:0]               RFDP_Vk;

    logic [CM_N-1:0]                RoBRF_en;
    logic [CM_N-1:0][REG_WIDTH:0]   RoBRF_rd;
    logic [CM_N-1:0][RoB_WIDTH-1:0] RoBRF_RoB_index;
    word_t [CM_N-1:0]               RoBRF_value;
    logic                           RoBRF_flush;

    logic [REG_WIDTH-1:0]           DBG_addr;
    word_t                          DBG_data;

    modport master (
        output Sys_rdy,
        output DPRF_en, DPRF_rd, DPRF_rs1, DPRF_rs2, DPRF_RoB_index,
        input  RFDP_Qj, RFDP_Qk, RFDP_Vj, RFDP_Vk,
        output RoBRF_en, RoBRF_rd, RoBRF_RoB_index, RoBRF_value,
        output RoBRF_flush, DBG_addr,
        input  DBG_data
    );

    modport slave (
        input  Sys_rdy,
        input  DPRF_en, DPRF_rd, DPRF_rs1, DPRF_rs2, DPRF_RoB_index,
        output RFDP_Qj, RFDP_Qk, RFDP_Vj, RFDP_Vk,
        input  RoBRF_en, RoBRF_rd, RoBRF_RoB_index, RoBRF_value,
        input  RoBRF_flush, DBG_addr,
        output DBG_data
    );

endinterface

// File: rtl/rf_src_lookup.sv
// Zero-latency tag/value resolution of one dispatch source operand.
module rf_src_lookup #(
    parameter int REG_WIDTH = register_file_mp_pkg::REG_WIDTH,
    parameter int RoB_WIDTH = register_file_mp_pkg::RoB_WIDTH,
    parameter int DP_N      = register_file_mp_pkg::DP_N,
    parameter int CM_N      = register_file_mp_pkg::CM_N
) (
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [REG_WIDTH:0]             rs,
    input  logic [RoB_WIDTH:0]             dep,
    input  register_file_mp_pkg::word_t    val,
    input  logic [DP_N-1:0]                byp_en,
    input  logic [DP_N-1:0][REG_WIDTH:0]   byp_rd,
    input  logic [DP_N-1:0][RoB_WIDTH-1:0] byp_tag,
    input  logic [CM_N-1:0]                cm_en,
    input  logic [CM_N-1:0][RoB_WIDTH-1:0] cm_tag,
    input  register_file_mp_pkg::word_t [CM_N-1:0] cm_value,
    output logic [RoB_WIDTH:0]             q,
    output register_file_mp_pkg::word_t    v
);
    import register_file_mp_pkg::word_t;

    localparam int EX_RoB_WIDTH = RoB_WIDTH + 1;
    localparam int NON_DEP      = 1 << RoB_WIDTH;

    logic is_reg;

    assign is_reg = !rs[REG_WIDTH] && (rs[REG_WIDTH-1:0] != '0);

    always_comb begin
        q = dep;
        v = (dep == EX_RoB_WIDTH'(NON_DEP)) ? val : '0;
        for (int i = 0; i < CM_N; i++) begin
            if (cm_en[i] && (dep == {1'b0, cm_tag[i]})) begin
                q = EX_RoB_WIDTH'(NON_DEP);
                v = cm_value[i];
            end
        end
        // byp_en already holds only older, architecturally valid writers
        for (int j = 0; j < DP_N; j++) begin
            if (byp_en[j] && (byp_rd[j] == rs)) begin
                q = {1'b0, byp_tag[j]};
                v = '0;
            end
        end
        if (!is_reg) begin
            q = EX_RoB_WIDTH'(NON_DEP);
            v = '0;
        end
        if (flush) q = EX_RoB_WIDTH'(NON_DEP);
        if (!rst_n) begin
            q = EX_RoB_WIDTH'(NON_DEP);
            v = '0;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port architectural register file with RoB dependency tags.
module register_file_mp #(
    parameter int REG_WIDTH = register_file_mp_pkg::REG_WIDTH,
    parameter int RoB_WIDTH = register_file_mp_pkg::RoB_WIDTH,
    parameter int DP_N      = register_file_mp_pkg::DP_N,
    parameter int CM_N      = register_file_mp_pkg::CM_N
) (
    input  logic               Sys_clk,
    input  logic               Sys_rst,
    register_file_mp_if.slave  bus
);
    import register_file_mp_pkg::word_t;

    localparam int EX_REG_WIDTH = REG_WIDTH + 1;
    localparam int NON_REG      = 1 << REG_WIDTH;
    localparam int EX_RoB_WIDTH = RoB_WIDTH + 1;
    localparam int NON_DEP      = 1 << RoB_WIDTH;

    word_t                   regs  [NON_REG];
    logic [EX_RoB_WIDTH-1:0] dep   [NON_REG];
    logic [EX_RoB_WIDTH-1:0] dep_n [NON_REG];

    logic [DP_N-1:0] disp_ok;
    logic [CM_N-1:0] cm_ok;

    always_comb begin
        for (int k = 0; k < DP_N; k++) begin
            disp_ok[k] = bus.DPRF_en[k] && !bus.DPRF_rd[k][REG_WIDTH]
                       && (bus.DPRF_rd[k][REG_WIDTH-1:0] != '0);
        end
        for (int i = 0; i < CM_N; i++) begin
            cm_ok[i] = bus.RoBRF_en[i] && !bus.RoBRF_rd[i][REG_WIDTH]
                     && (bus.RoBRF_rd[i][REG_WIDTH-1:0] != '0);
        end
    end

    // Clears first, dispatch sets after: a same-cycle rename wins.
    always_comb begin
        dep_n = dep;
        for (int i = 0; i < CM_N; i++) begin
            if (cm_ok[i] && dep[bus.RoBRF_rd[i][REG_WIDTH-1:0]]
                            == {1'b0, bus.RoBRF_RoB_index[i]})
                dep_n[bus.RoBRF_rd[i][REG_WIDTH-1:0]] =
                    EX_RoB_WIDTH'(NON_DEP);
        end
        for (int k = 0; k < DP_N; k++) begin
            if (disp_ok[k])
                dep_n[bus.DPRF_rd[k][REG_WIDTH-1:0]] =
                    {1'b0, bus.DPRF_RoB_index[k]};
        end
        if (bus.RoBRF_flush) begin
            for (int r = 0; r < NON_REG; r++)
                dep_n[r] = EX_RoB_WIDTH'(NON_DEP);
        end
    end

    always_ff @(posedge Sys_clk or negedge Sys_rst) begin
        if (!Sys_rst) begin
            for (int r = 0; r < NON_REG; r++) begin
                regs[r] <= '0;
                dep[r]  <= EX_RoB_WIDTH'(NON_DEP);
            end
        end else if (bus.Sys_rdy) begin
            for (int r = 0; r < NON_REG; r++)
                dep[r] <= dep_n[r];
            for (int i = 0; i < CM_N; i++) begin
                if (cm_ok[i])
                    regs[bus.RoBRF_rd[i][REG_WIDTH-1:0]] <=
                        bus.RoBRF_value[i];
            end
        end
    end

    assign bus.DBG_data = regs[bus.DBG_addr];

    logic [EX_RoB_WIDTH-1:0] qj [DP_N];
    logic [EX_RoB_WIDTH-1:0] qk [DP_N];
    word_t                   vj [DP_N];
    word_t                   vk [DP_N];

    for (genvar k = 0; k < DP_N; k++) begin : g_src
        localparam logic [DP_N-1:0] OLDER = DP_N'((1 << k) - 1);
        logic [DP_N-1:0]     byp_en;
        logic [REG_WIDTH-1:0] idx1;
        logic [REG_WIDTH-1:0] idx2;

        assign byp_en = disp_ok & OLDER;
        assign idx1   = bus.DPRF_rs1[k][REG_WIDTH-1:0];
        assign idx2   = bus.DPRF_rs2[k][REG_WIDTH-1:0];

        rf_src_lookup #(
            .REG_WIDTH(REG_WIDTH), .RoB_WIDTH(RoB_WIDTH),
            .DP_N(DP_N), .CM_N(CM_N)
        ) u_rs1 (
            .rst_n   (Sys_rst),
            .flush   (bus.RoBRF_flush),
            .rs      (bus.DPRF_rs1[k]),
            .dep     (dep[idx1]),
            .val     (regs[idx1]),
            .byp_en  (byp_en),
            .byp_rd  (bus.DPRF_rd),
            .byp_tag (bus.DPRF_RoB_index),
            .cm_en   (bus.RoBRF_en),
            .cm_tag  (bus.RoBRF_RoB_index),
            .cm_value(bus.RoBRF_value),
            .q       (qj[k]),
            .v       (vj[k])
        );

        rf_src_lookup #(
            .REG_WIDTH(REG_WIDTH), .RoB_WIDTH(RoB_WIDTH),
            .DP_N(DP_N), .CM_N(CM_N)
        ) u_rs2 (
            .rst_n   (Sys_rst),
            .flush   (bus.RoBRF_flush),
            .rs      (bus.DPRF_rs2[k]),
            .dep     (dep[idx2]),
            .val     (regs[idx2]),
            .byp_en  (byp_en),
            .byp_rd  (bus.DPRF_rd),
            .byp_tag (bus.DPRF_RoB_index),
            .cm_en   (bus.RoBRF_en),
            .cm_tag  (bus.RoBRF_RoB_index),
            .cm_value(bus.RoBRF_value),
            .q       (qk[k]),
            .v       (vk[k])
        );

        assign bus.RFDP_Qj[k] = qj[k];
        assign bus.RFDP_Qk[k] = qk[k];
        assign bus.RFDP_Vj[k] = vj[k];
        assign bus.RFDP_Vk[k] = vk[k];
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed scoreboard bench for register_file_mp.
module tb_register_file_mp;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    localparam int NDEP = 16;
    localparam int NREG = 32;

    logic Sys_clk = 1'b0;
    logic Sys_rst = 1'b0;
    logic strobe  = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    exp_t sb[$];

    register_file_mp_if bus ();

    register_file_mp dut (
        .Sys_clk(Sys_clk),
        .Sys_rst(Sys_rst),
        .bus    (bus)
    );

    always #5 Sys_clk = ~Sys_clk;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0: observe = 32'(bus.RFDP_Qj[0]);
            1: observe = 32'(bus.RFDP_Qj[1]);
            2: observe = 32'(bus.RFDP_Qk[0]);
            3: observe = 32'(bus.RFDP_Qk[1]);
            4: observe = bus.RFDP_Vj[0];
            5: observe = bus.RFDP_Vj[1];
            6: observe = bus.RFDP_Vk[0];
            7: observe = bus.RFDP_Vk[1];
            default: observe = bus.DBG_data;
        endcase
    endfunction

    always @(strobe) begin
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] got;
            e   = sb.pop_front();
            got = observe(e.sel);
            vectors++;
            if (got !== e.exp) begin
                miscompares++;
                $display("FAIL %s got=%h expected=%h", e.name, got, e.exp);
            end
        end
    end

    task automatic expect_val(input int sel, input logic [31:0] v,
                              input string name);
        exp_t e;
        e.sel  = sel;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic check();
        strobe = ~strobe;
        #2;
    endtask

    task automatic tick();
        @(posedge Sys_clk);
        #1;
    endtask

    task automatic idle();
        bus.Sys_rdy         = 1'b1;
        bus.DPRF_en         = '0;
        bus.DPRF_rd         = '0;
        bus.DPRF_rs1        = '0;
        bus.DPRF_rs2        = '0;
        bus.DPRF_RoB_index  = '0;
        bus.RoBRF_en        = '0;
        bus.RoBRF_rd        = '0;
        bus.RoBRF_RoB_index = '0;
        bus.RoBRF_value     = '0;
        bus.RoBRF_flush     = 1'b0;
        bus.DBG_addr        = '0;
    endtask

    task automatic disp(input int s, input int rd, input int tag);
        bus.DPRF_en[s]        = 1'b1;
        bus.DPRF_rd[s]        = 6'(rd);
        bus.DPRF_RoB_index[s] = 4'(tag);
    endtask

    task automatic commit(input int s, input int rd, input int tag,
                          input logic [31:0] val);
        bus.RoBRF_en[s]        = 1'b1;
        bus.RoBRF_rd[s]        = 6'(rd);
        bus.RoBRF_RoB_index[s] = 4'(tag);
        bus.RoBRF_value[s]     = val;
    endtask

    initial begin
        idle();
        #1;
        // held in reset: bypass and table must be masked
        disp(0, 5, 3);
        bus.DPRF_rs1[1] = 6'd5;
        bus.DBG_addr    = 5'd5;
        expect_val(1, NDEP, "rst_qj1");
        expect_val(5, 0, "rst_vj1");
        expect_val(8, 0, "rst_dbg5");
        check();
        @(negedge Sys_clk);
        Sys_rst = 1'b1;
        tick();

        idle();
        disp(0, 5, 3);
        bus.DPRF_rs2[0] = 6'd32;
        expect_val(0, NDEP, "x0_qj0");
        expect_val(4, 0, "x0_vj0");
        expect_val(2, NDEP, "nonreg_qk0");
        check();
        tick();

        idle();
        disp(0, 7, 2);
        bus.DPRF_rs1[0] = 6'd5;
        bus.DPRF_rs1[1] = 6'd5;
        bus.DPRF_rs2[1] = 6'd7;
        expect_val(0, 3, "dep_x5_qj0");
        expect_val(4, 0, "dep_x5_vj0");
        expect_val(1, 3, "dep_x5_qj1");
        expect_val(3, 2, "byp_x7_qk1");
        expect_val(7, 0, "byp_x7_vk1");
        check();
        tick();

        idle();
        commit(0, 5, 3, 32'hDEAD);
        commit(1, 8, 9, 32'h1111);
        bus.DPRF_rs1[0] = 6'd5;
        bus.DPRF_rs2[1] = 6'd7;
        expect_val(0, NDEP, "cm_fwd_qj0");
        expect_val(4, 32'hDEAD, "cm_fwd_vj0");
        expect_val(3, 2, "table_x7_qk1");
        check();
        tick();

        idle();
        disp(0, 9, 4);
        bus.DPRF_rs1[0] = 6'd5;
        bus.DPRF_rs2[0] = 6'd8;
        bus.DBG_addr    = 5'd5;
        expect_val(0, NDEP, "cleared_x5_qj0");
        expect_val(4, 32'hDEAD, "reg_x5_vj0");
        expect_val(8, 32'hDEAD, "dbg_x5");
        expect_val(2, NDEP, "x8_qk0");
        expect_val(6, 32'h1111, "x8_vk0");
        check();
        tick();

        idle();
        commit(0, 9, 4, 32'h99);
        disp(1, 9, 6);
        bus.DPRF_rs1[0] = 6'd9;
        bus.DPRF_rs1[1] = 6'd9;
        expect_val(0, NDEP, "cm_x9_qj0");
        expect_val(4, 32'h99, "cm_x9_vj0");
        expect_val(1, NDEP, "cm_x9_qj1");
        expect_val(5, 32'h99, "cm_x9_vj1");
        check();
        tick();

        idle();
        commit(0, 10, 0, 32'd1);
        commit(1, 10, 0, 32'd2);
        disp(0, 11, 1);
        disp(1, 11, 5);
        bus.DPRF_rs1[0] = 6'd9;
        bus.DPRF_rs2[1] = 6'd11;
        bus.DBG_addr    = 5'd9;
        expect_val(0, 6, "disp_beats_clr_qj0");
        expect_val(4, 0, "disp_beats_clr_vj0");
        expect_val(8, 32'h99, "dbg_x9");
        expect_val(3, 1, "byp_x11_qk1");
        check();
        tick();

        idle();
        bus.Sys_rdy = 1'b0;
        disp(0, 12, 7);
        commit(0, 13, 0, 32'd3);
        bus.DPRF_rs1[0] = 6'd11;
        bus.DPRF_rs2[0] = 6'd7;
        bus.DBG_addr    = 5'd10;
        expect_val(8, 2, "cm_hi_slot_x10");
        expect_val(0, 5, "disp_hi_slot_x11");
        expect_val(2, 2, "hold_x7_qk0");
        check();
        tick();

        idle();
        bus.DPRF_rs1[0] = 6'd12;
        bus.DBG_addr    = 5'd13;
        expect_val(0, NDEP, "rdy0_no_dep_x12");
        expect_val(8, 0, "rdy0_no_wr_x13");
        check();
        tick();

        idle();
        bus.RoBRF_flush = 1'b1;
        disp(0, 3, 1);
        commit(0, 14, 0, 32'h44);
        bus.DPRF_rs1[1] = 6'd3;
        bus.DPRF_rs2[0] = 6'd11;
        bus.DPRF_rs2[1] = 6'd7;
        expect_val(1, NDEP, "flush_qj1");
        expect_val(2, NDEP, "flush_qk0");
        expect_val(3, NDEP, "flush_qk1");
        check();
        tick();

        idle();
        bus.DPRF_rs1[0] = 6'd3;
        bus.DPRF_rs2[0] = 6'd11;
        bus.DPRF_rs1[1] = 6'd9;
        bus.DBG_addr    = 5'd14;
        expect_val(0, NDEP, "post_flush_x3");
        expect_val(2, NDEP, "post_flush_x11");
        expect_val(1, NDEP, "post_flush_x9_q");
        expect_val(5, 32'h99, "post_flush_x9_v");
        expect_val(8, 32'h44, "flush_cm_wr_x14");
        check();

        Sys_rst = 1'b0;
        for (int a = 0; a < NREG; a++) begin
            idle();
            bus.DBG_addr    = 5'(a);
            bus.DPRF_rs1[0] = 6'd9;
            expect_val(8, 0, $sformatf("rst_dbg_x%0d", a));
            if (a == 0) expect_val(4, 0, "rst_vj0_x9");
            check();
            tick();
        end
        @(negedge Sys_clk);
        Sys_rst = 1'b1;
        tick();

        idle();
        commit(0, 0, 0, 32'hFFFF);
        bus.DPRF_rs1[0] = 6'd9;
        expect_val(0, NDEP, "after_rst_q_x9");
        expect_val(4, 0, "after_rst_v_x9");
        check();
        tick();

        idle();
        bus.DBG_addr = 5'd0;
        expect_val(8, 0, "x0_write_ignored");
        check();

        #5;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain left=%0d", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
